// File: rtl/cv32e40x_pkg.sv
// Shared types for the WFI sleep sequencer.
//   wfi_seq_state_e : sequencer FSM encoding
//   WakeCntW        : width of the WAKE-phase cycle counter (covers WAKE_DLY up to 15)
//   DrainCntW       : width of the DRAIN timeout counter (covers DRAIN_MAX up to 255)
package cv32e40x_pkg;

  localparam int unsigned WakeCntW  = 4;
  localparam int unsigned DrainCntW = 8;

  typedef enum logic [2:0] {
    WfiOff   = 3'd0,
    WfiRun   = 3'd1,
    WfiDrain = 3'd2,
    WfiSleep = 3'd3,
    WfiWake  = 3'd4
  } wfi_seq_state_e;

endpackage

// File: rtl/cv32e40x_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst_n : asynchronous active-low reset, counter to 0
//   clr   : synchronous clear; wins over inc
//   inc   : add one, holding at all-ones
//   cnt   : current count
module cv32e40x_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cv32e40x_wfi_sequencer.sv
// WFI sleep sequencer: drains outstanding bus traffic, stops the core clock while
// asleep and restarts it on an interrupt or debug request.
//   clk_ungated_i  : free-running clock
//   rst_n          : asynchronous active-low reset
//   fetch_enable_i : fetch enable, sticky once sampled high
//   wfi_req_i      : WFI retiring, held until wfi_ack_o
//   wfi_ack_o      : one-cycle pulse completing the WFI
//   irq_wu_i       : pending enabled interrupt (wake source)
//   debug_req_i    : debug request (wake source)
//   debug_mode_i   : core in debug mode, sleep forbidden
//   if_busy_i      : outstanding fetch transactions
//   lsu_busy_i     : outstanding data transactions
//   cnt_clr_i      : synchronous clear of sleep_cnt_o
//   clock_en_o     : enable for the external core clock gate
//   core_sleep_o   : core is asleep
//   halt_pipe_o    : stall fetch/issue
//   drain_err_o    : one-cycle pulse on drain timeout
//   sleep_cnt_o    : cycles spent asleep (saturating)
module cv32e40x_wfi_sequencer
  import cv32e40x_pkg::*;
#(
  parameter int unsigned WAKE_DLY  = 2,
  parameter int unsigned DRAIN_MAX = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             fetch_enable_i,
  input  logic             wfi_req_i,
  output logic             wfi_ack_o,
  input  logic             irq_wu_i,
  input  logic             debug_req_i,
  input  logic             debug_mode_i,
  input  logic             if_busy_i,
  input  logic             lsu_busy_i,
  input  logic             cnt_clr_i,
  output logic             clock_en_o,
  output logic             core_sleep_o,
  output logic             halt_pipe_o,
  output logic             drain_err_o,
  output logic [CNT_W-1:0] sleep_cnt_o
);

  // WAKE lasts at least one cycle even when WAKE_DLY is 0.
  localparam logic [WakeCntW-1:0]  WakeLast  =
      (WAKE_DLY > 1) ? WakeCntW'(WAKE_DLY - 1) : '0;
  localparam logic [DrainCntW-1:0] DrainLast = DrainCntW'(DRAIN_MAX - 1);

  wfi_seq_state_e       state_q, state_d;
  logic                 fetch_en_q;
  logic [DrainCntW-1:0] drain_cnt_q;
  logic [WakeCntW-1:0]  wake_cnt_q;
  logic                 wake;

  assign wake = irq_wu_i | debug_req_i;

  // Outputs decode the current state (plus wake in SLEEP/RUN) so that the ack in
  // RUN and the clock restart in SLEEP land in the same cycle as their cause.
  always_comb begin
    state_d      = state_q;
    wfi_ack_o    = 1'b0;
    drain_err_o  = 1'b0;
    clock_en_o   = 1'b0;
    core_sleep_o = 1'b0;
    halt_pipe_o  = 1'b1;
    unique case (state_q)
      WfiOff: begin
        if (fetch_enable_i || fetch_en_q) begin
          state_d = WfiRun;
        end
      end
      WfiRun: begin
        clock_en_o  = 1'b1;
        halt_pipe_o = 1'b0;
        if (wfi_req_i) begin
          if (wake || debug_mode_i) begin
            // Sleep pointless or forbidden: retire the WFI as a NOP.
            wfi_ack_o = 1'b1;
          end else begin
            state_d = WfiDrain;
          end
        end
      end
      WfiDrain: begin
        clock_en_o = 1'b1;
        if (wake) begin
          state_d = WfiWake;
        end else if (!if_busy_i && !lsu_busy_i) begin
          state_d = WfiSleep;
        end else if (drain_cnt_q == DrainLast) begin
          state_d     = WfiRun;
          drain_err_o = 1'b1;
          wfi_ack_o   = 1'b1;
        end
      end
      WfiSleep: begin
        core_sleep_o = 1'b1;
        clock_en_o   = wake;
        if (wake) begin
          state_d = WfiWake;
        end
      end
      WfiWake: begin
        clock_en_o = 1'b1;
        if (wake_cnt_q == WakeLast) begin
          state_d   = WfiRun;
          wfi_ack_o = 1'b1;
        end
      end
      default: begin
        state_d = WfiOff;
      end
    endcase
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WfiOff;
      fetch_en_q  <= 1'b0;
      drain_cnt_q <= '0;
      wake_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_enable_i) begin
        fetch_en_q <= 1'b1;
      end
      // Counters sit at 0 outside their state, so each entry starts from 0.
      if (state_q != WfiDrain) begin
        drain_cnt_q <= '0;
      end else if (drain_cnt_q != '1) begin
        drain_cnt_q <= drain_cnt_q + DrainCntW'(1);
      end
      if (state_q != WfiWake) begin
        wake_cnt_q <= '0;
      end else if (wake_cnt_q != '1) begin
        wake_cnt_q <= wake_cnt_q + WakeCntW'(1);
      end
    end
  end

  cv32e40x_sat_counter #(
    .WIDTH (CNT_W)
  ) u_sleep_cnt (
    .clk   (clk_ungated_i),
    .rst_n (rst_n),
    .clr   (cnt_clr_i),
    .inc   (state_q == WfiSleep),
    .cnt   (sleep_cnt_o)
  );

endmodule

// File: tb/tb_cv32e40x_wfi_sequencer.sv
module tb_cv32e40x_wfi_sequencer;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable = 1'b0, wfi_req = 1'b0, irq_wu = 1'b0, debug_req = 1'b0;
  logic        debug_mode = 1'b0, if_busy = 1'b0, lsu_busy = 1'b0, cnt_clr = 1'b0;
  logic        wfi_ack, clock_en, core_sleep, halt_pipe, drain_err;
  logic [31:0] sleep_cnt;
  logic        ack4, clken4, sleep4, halt4, err4;
  logic [3:0]  sleep_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cv32e40x_wfi_sequencer dut (
    .clk_ungated_i (clk),        .rst_n        (rst_n),
    .fetch_enable_i(fetch_enable), .wfi_req_i  (wfi_req),
    .wfi_ack_o     (wfi_ack),    .irq_wu_i     (irq_wu),
    .debug_req_i   (debug_req),  .debug_mode_i (debug_mode),
    .if_busy_i     (if_busy),    .lsu_busy_i   (lsu_busy),
    .cnt_clr_i     (cnt_clr),    .clock_en_o   (clock_en),
    .core_sleep_o  (core_sleep), .halt_pipe_o  (halt_pipe),
    .drain_err_o   (drain_err),  .sleep_cnt_o  (sleep_cnt)
  );

  cv32e40x_wfi_sequencer #(.CNT_W(4)) dut4 (
    .clk_ungated_i (clk),        .rst_n        (rst_n),
    .fetch_enable_i(fetch_enable), .wfi_req_i  (wfi_req),
    .wfi_ack_o     (ack4),       .irq_wu_i     (irq_wu),
    .debug_req_i   (debug_req),  .debug_mode_i (debug_mode),
    .if_busy_i     (if_busy),    .lsu_busy_i   (lsu_busy),
    .cnt_clr_i     (cnt_clr),    .clock_en_o   (clken4),
    .core_sleep_o  (sleep4),     .halt_pipe_o  (halt4),
    .drain_err_o   (err4),       .sleep_cnt_o  (sleep_cnt4)
  );

  // Illegal stimulus: WFI request withdrawn while draining.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(dut.state_q == WfiDrain && !wfi_req))
        else $error("FAIL wfi_req_drop: wfi_req=0 in DRAIN");
      assert (!(core_sleep && clock_en && !(dut.state_q == WfiSleep && (irq_wu || debug_req))))
        else $error("FAIL sleep_clk_excl: core_sleep=1 clock_en=1 without wake in SLEEP");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns at the falling edge of the ack cycle.
  task automatic await_ack(input string tag, input int budget, output int ncyc);
    bit   got;
    exp_t e;
    got  = 1'b0;
    ncyc = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (wfi_ack) begin
        ncyc = k;
        got  = 1'b1;
        break;
      end
      n_checks++;
      if (drain_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_err_early: drain_err=%0b, required 0", tag, drain_err);
      end
      step();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_ack_timeout: no wfi_ack within %0d cycles", tag, budget);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected_ack: ack with empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      if (e.tag != tag || drain_err !== e.err ||
          (e.chk_cnt && sleep_cnt !== e.cnt)) begin
        n_fail++;
        $display("FAIL %s_ack: tag=%s err=%0b cnt=%0d, required tag=%s err=%0b cnt=%0d",
                 tag, tag, drain_err, sleep_cnt, e.tag, e.err, e.cnt);
      end
    end
  endtask

  task automatic test_reset();
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({clock_en, core_sleep, halt_pipe, wfi_ack, drain_err} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00100",
               {clock_en, core_sleep, halt_pipe, wfi_ack, drain_err});
    end
    n_checks++;
    if (dut.state_q !== WfiOff || sleep_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cnt=%0d, required 0 0", dut.state_q, sleep_cnt);
    end
  endtask

  task automatic test_fetch_enable();
    step(); rst_n = 1'b1;               // cycle 0
    step(); step(); step();             // cycle 3
    fetch_enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiOff || clock_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_cycle3: state=%0d clock_en=%0b, required 0 0", dut.state_q, clock_en);
    end
    step();                             // cycle 4
    fetch_enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiRun || {clock_en, halt_pipe} !== 2'b10) begin
      n_fail++;
      $display("FAIL fe_cycle4: state=%0d clk/halt=%b, required 1 10",
               dut.state_q, {clock_en, halt_pipe});
    end
  endtask

  task automatic test_sleep_wake();
    int n;
    step();
    wfi_req = 1'b1;
    exp_q.push_back('{tag: "sleep_wake", err: 1'b0, chk_cnt: 1'b1, cnt: 32'd10});
    step();
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiDrain) begin
      n_fail++;
      $display("FAIL sw_drain: state=%0d, required %0d", dut.state_q, WfiDrain);
    end
    step();                             // SLEEP cycle 1
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiSleep || {clock_en, core_sleep} !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_sleep: state=%0d clk/sleep=%b, required %0d 01",
               dut.state_q, {clock_en, core_sleep}, WfiSleep);
    end
    repeat (9) step();                  // SLEEP cycle 10
    irq_wu = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clock_en, core_sleep} !== 2'b11) begin
      n_fail++;
      $display("FAIL sw_wake_clk: clk/sleep=%b, required 11", {clock_en, core_sleep});
    end
    step();
    irq_wu = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiWake || wfi_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wake1: state=%0d ack=%0b, required %0d 0", dut.state_q, wfi_ack, WfiWake);
    end
    step();
    await_ack("sleep_wake", 3, n);
    n_checks++;
    if (n !== 1 || dut.state_q !== WfiWake) begin
      n_fail++;
      $display("FAIL sw_wake_len: ack in cycle %0d state=%0d, required 1 %0d", n, dut.state_q,
               WfiWake);
    end
    step();
    wfi_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiRun || wfi_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_run: state=%0d ack=%0b, required %0d 0", dut.state_q, wfi_ack, WfiRun);
    end
  endtask

  task automatic test_wfi_nop();
    int n;
    for (int v = 0; v < 2; v++) begin
      step();
      wfi_req    = 1'b1;
      irq_wu     = (v == 0);
      debug_mode = (v == 1);
      exp_q.push_back('{tag: "wfi_nop", err: 1'b0, chk_cnt: 1'b0, cnt: 32'd0});
      await_ack("wfi_nop", 1, n);
      step();
      wfi_req    = 1'b0;
      irq_wu     = 1'b0;
      debug_mode = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut.state_q !== WfiRun || core_sleep !== 1'b0 || wfi_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wfi_nop_%0d: state=%0d sleep=%0b ack=%0b, required %0d 0 0",
                 v, dut.state_q, core_sleep, wfi_ack, WfiRun);
      end
    end
  endtask

  task automatic test_drain_timeout();
    int n;
    step();
    wfi_req  = 1'b1;
    lsu_busy = 1'b1;
    exp_q.push_back('{tag: "drain_to", err: 1'b1, chk_cnt: 1'b0, cnt: 32'd0});
    step();                             // DRAIN cycle 1
    await_ack("drain_to", 80, n);
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL drain_to_cycle: ack in DRAIN cycle %0d, required 64", n);
    end
    step();
    wfi_req  = 1'b0;
    lsu_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiRun || drain_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_to_run: state=%0d err=%0b, required %0d 0", dut.state_q, drain_err,
               WfiRun);
    end
  endtask

  task automatic test_debug_priority();
    int n;
    step();
    wfi_req = 1'b1;
    exp_q.push_back('{tag: "dbg_prio", err: 1'b0, chk_cnt: 1'b0, cnt: 32'd0});
    step();
    debug_req = 1'b1;
    step();
    debug_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiWake || core_sleep !== 1'b0) begin
      n_fail++;
      $display("FAIL dbg_prio: state=%0d sleep=%0b, required %0d 0", dut.state_q, core_sleep,
               WfiWake);
    end
    step();
    await_ack("dbg_prio", 3, n);
    step();
    wfi_req = 1'b0;
  endtask

  task automatic test_saturate_and_reset();
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sleep_cnt4 !== 4'd0 || sleep_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_idle: cnt4=%0d cnt=%0d, required 0 0", sleep_cnt4, sleep_cnt);
    end
    step();
    wfi_req = 1'b1;
    step();                             // DRAIN
    step();                             // SLEEP cycle 1
    repeat (19) step();                 // SLEEP cycle 20
    @(negedge clk);
    n_checks++;
    if (sleep_cnt4 !== 4'd15 || sleep_cnt !== 32'd19) begin
      n_fail++;
      $display("FAIL sat_cnt: cnt4=%0d cnt=%0d, required 15 19", sleep_cnt4, sleep_cnt);
    end
    n_checks++;
    if ({ack4, clken4, sleep4, halt4, err4} !== 5'b00110) begin
      n_fail++;
      $display("FAIL sat_outputs: got %b, required 00110", {ack4, clken4, sleep4, halt4, err4});
    end
    step();
    cnt_clr = 1'b1;                     // clear while incrementing
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sleep_cnt4 !== 4'd0 || sleep_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_prio: cnt4=%0d cnt=%0d, required 0 0", sleep_cnt4, sleep_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.state_q !== WfiOff || {core_sleep, clock_en, halt_pipe} !== 3'b001) begin
      n_fail++;
      $display("FAIL sleep_reset: state=%0d sleep/clk/halt=%b, required 0 001",
               dut.state_q, {core_sleep, clock_en, halt_pipe});
    end
    wfi_req = 1'b0;
  endtask

  task automatic test_restart();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiOff || clock_en !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_off: state=%0d clock_en=%0b, required 0 0", dut.state_q, clock_en);
    end
    step();
    fetch_enable = 1'b1;
    step();
    fetch_enable = 1'b0;
    repeat (2) step();
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== WfiRun || halt_pipe !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_run: state=%0d halt=%0b, required %0d 0", dut.state_q, halt_pipe,
               WfiRun);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_enable();
    test_sleep_wake();
    test_wfi_nop();
    test_drain_timeout();
    test_debug_priority();
    test_saturate_and_reset();
    test_restart();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d expected acks never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
